multicycle_control: RTL and testbench

Multi-cycle sequencer for the RV32I core. Each instruction is executed over 3–5 clock cycles on a shared ALU, a unified instruction/data memory port and one PC/IR register set. The block holds the instruction-step FSM and, in every state, drives the datapath mux selects, register-write strobes, ALU operation and immediate type. It replaces the single-cycle decoder when the core is built in multi-cycle form.

---
 rtl/multicycle_control_if.sv | 38 +++
 rtl/multicycle_control.sv | 256 +++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multi-cycle sequencer and the RV32I datapath.
// master: the sequencer (multicycle_control); slave: the datapath side.
interface multicycle_control_if;
    // Datapath -> sequencer
    logic [6:0] op_code;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       zero;
    logic       mem_ready;

    // Sequencer -> datapath
    logic       pc_write;
    logic       ir_write;
    logic       adr_source;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_source;
    logic [1:0] alu_source_a;
    logic [1:0] alu_source_b;
    logic [2:0] alu_control;
    logic [2:0] imm_type;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  op_code, func3, func7, zero, mem_ready,
        output pc_write, ir_write, adr_source, mem_write, reg_write,
        output result_source, alu_source_a, alu_source_b, alu_control,
        output imm_type, instr_done, illegal
    );

    modport slave (
        output op_code, func3, func7, zero, mem_ready,
        input  pc_write, ir_write, adr_source, mem_write, reg_write,
        input  result_source, alu_source_a, alu_source_b, alu_control,
        input  imm_type, instr_done, illegal
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I instruction sequencer: instruction-step FSM driving the
// shared-ALU datapath selects, register/memory strobes, ALU op and immediate type.
// Build option MEM_WAIT_EN: when defined, mem_ready stalls FETCH/MEMREAD/MEMWRITE;
// when undefined, mem_ready is ignored and treated as always 1.
module multicycle_control (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_JAL,
        S_BEQ,
        S_TRAP
    } state_t;

    state_t state_q;
    state_t state_d;

    // Effective memory handshake and instruction classification
    logic       ready;
    logic       is_load;
    logic       is_store;
    logic       is_rtype;
    logic       is_ialu;
    logic       is_branch;
    logic       is_jal;
    logic       alu_f3_ok;
    logic [2:0] alu_r;
    logic [2:0] alu_i;
    logic       unused_inputs;

    // Ungated outputs of the current state, before reset masking
    logic       pc_write_raw;
    logic       ir_write_raw;
    logic       adr_source_raw;
    logic       mem_write_raw;
    logic       reg_write_raw;
    logic [1:0] result_source_raw;
    logic [1:0] alu_source_a_raw;
    logic [1:0] alu_source_b_raw;
    logic [2:0] alu_control_raw;
    logic       instr_done_raw;
    logic       illegal_raw;

    // func3 -> ALU operation; sub_en selects SUB for func3 000
    function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_en);
        logic [2:0] op;
        op = ALU_ADD;
        case (f3)
            3'b000:  op = sub_en ? ALU_SUB : ALU_ADD;
            3'b111:  op = ALU_AND;
            3'b110:  op = ALU_OR;
            3'b010:  op = ALU_SLT;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // Memory ready source: honoured only in the wait-state build
    always_comb begin
`ifdef MEM_WAIT_EN
        ready         = bus.mem_ready;
        unused_inputs = ^{bus.func7[6], bus.func7[4:0]};
`else
        ready         = 1'b1;
        unused_inputs = ^{bus.func7[6], bus.func7[4:0], bus.mem_ready};
`endif
    end

    // Opcode classification, ALU decode and immediate type (state independent)
    always_comb begin
        is_load   = (bus.op_code == OP_LOAD);
        is_store  = (bus.op_code == OP_STORE);
        is_rtype  = (bus.op_code == OP_RTYPE);
        is_ialu   = (bus.op_code == OP_IALU);
        is_branch = (bus.op_code == OP_BRANCH);
        is_jal    = (bus.op_code == OP_JAL);
        alu_f3_ok = (bus.func3 == 3'b000) || (bus.func3 == 3'b010) ||
                    (bus.func3 == 3'b110) || (bus.func3 == 3'b111);
        alu_r     = alu_decode(bus.func3, bus.func7[5]);
        alu_i     = alu_decode(bus.func3, 1'b0);
        case (bus.op_code)
            OP_STORE:  bus.imm_type = IMM_S;
            OP_BRANCH: bus.imm_type = IMM_B;
            OP_JAL:    bus.imm_type = IMM_J;
            default:   bus.imm_type = IMM_I;
        endcase
    end

    // State register with synchronous reset into FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (ready) state_d = S_DECODE;
            S_DECODE: begin
                if (is_load || is_store)           state_d = S_MEMADR;
                else if (is_rtype && alu_f3_ok)    state_d = S_EXECUTER;
                else if (is_ialu && alu_f3_ok)     state_d = S_EXECUTEI;
                else if (is_branch && bus.func3 == 3'b000) state_d = S_BEQ;
                else if (is_jal)                   state_d = S_JAL;
                else                               state_d = S_TRAP;
            end
            S_MEMADR:   state_d = is_load ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (ready) state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_BEQ:      state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    // Per-state datapath controls; every output defaults to 0
    always_comb begin
        pc_write_raw      = 1'b0;
        ir_write_raw      = 1'b0;
        adr_source_raw    = 1'b0;
        mem_write_raw     = 1'b0;
        reg_write_raw     = 1'b0;
        result_source_raw = RES_ALUOUT;
        alu_source_a_raw  = SRCA_PC;
        alu_source_b_raw  = SRCB_RS2;
        alu_control_raw   = ALU_ADD;
        instr_done_raw    = 1'b0;
        illegal_raw       = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write_raw      = ready;
                pc_write_raw      = ready;
                alu_source_a_raw  = SRCA_PC;
                alu_source_b_raw  = SRCB_FOUR;
                result_source_raw = RES_ALURESULT;
            end
            S_DECODE: begin
                alu_source_a_raw = SRCA_OLDPC;
                alu_source_b_raw = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_source_a_raw = SRCA_RS1;
                alu_source_b_raw = SRCB_IMM;
            end
            S_MEMREAD: begin
                adr_source_raw = 1'b1;
            end
            S_MEMWB: begin
                result_source_raw = RES_MEMDATA;
                reg_write_raw     = 1'b1;
                instr_done_raw    = 1'b1;
            end
            S_MEMWRITE: begin
                adr_source_raw = 1'b1;
                mem_write_raw  = 1'b1;
                instr_done_raw = ready;
            end
            S_EXECUTER: begin
                alu_source_a_raw = SRCA_RS1;
                alu_source_b_raw = SRCB_RS2;
                alu_control_raw  = alu_r;
            end
            S_EXECUTEI: begin
                alu_source_a_raw = SRCA_RS1;
                alu_source_b_raw = SRCB_IMM;
                alu_control_raw  = alu_i;
            end
            S_ALUWB: begin
                reg_write_raw  = 1'b1;
                instr_done_raw = 1'b1;
            end
            S_JAL: begin
                alu_source_a_raw = SRCA_OLDPC;
                alu_source_b_raw = SRCB_FOUR;
                pc_write_raw     = 1'b1;
            end
            S_BEQ: begin
                alu_source_a_raw = SRCA_RS1;
                alu_source_b_raw = SRCB_RS2;
                alu_control_raw  = ALU_SUB;
                pc_write_raw     = bus.zero;
                instr_done_raw   = 1'b1;
            end
            S_TRAP: begin
                illegal_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are masked while reset is high so an aborted instruction commits nothing
    always_comb begin
        bus.pc_write      = pc_write_raw   & ~reset;
        bus.ir_write      = ir_write_raw   & ~reset;
        bus.mem_write     = mem_write_raw  & ~reset;
        bus.reg_write     = reg_write_raw  & ~reset;
        bus.instr_done    = instr_done_raw & ~reset;
        bus.illegal       = illegal_raw    & ~reset;
        bus.adr_source    = adr_source_raw;
        bus.result_source = result_source_raw;
        bus.alu_source_a  = alu_source_a_raw;
        bus.alu_source_b  = alu_source_b_raw;
        bus.alu_control   = alu_control_raw;
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: each instruction is expanded into
// an expected per-cycle output table from the instruction-level rules, then
// replayed against the DUT with random stalls, zero flags and don't-care inputs.
module tb_multicycle_control;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IA  = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic       pcw;
        logic       irw;
        logic       adr;
        logic       mw;
        logic       rw;
        logic [1:0] res;
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] alu;
        logic [2:0] imm;
        logic       done;
        logic       ill;
    } outs_t;

    typedef struct {
        logic  mr;
        logic  z;
        outs_t e;
    } step_t;

    step_t       plan[$];
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    logic [6:0]  cur_op;
    logic [2:0]  cur_f3;
    logic [6:0]  cur_f7;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // mem_ready on a cycle that must complete the access
    function automatic logic need();
`ifdef MEM_WAIT_EN
        return 1'b1;
`else
        return rb();
`endif
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        if (op == SW)  return 3'b001;
        if (op == BEQ) return 3'b010;
        if (op == JAL) return 3'b011;
        return 3'b000;
    endfunction

    function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic sub);
        if (f3 == 3'b000) return sub ? 3'b001 : 3'b000;
        if (f3 == 3'b111) return 3'b010;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b010) return 3'b101;
        return 3'b000;
    endfunction

    function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
        if (op == LW || op == SW || op == JAL) return 1'b1;
        if (op == BEQ) return (f3 == 3'b000);
        if (op == RT || op == IA) return (f3 inside {3'b000, 3'b010, 3'b110, 3'b111});
        return 1'b0;
    endfunction

    function automatic outs_t mk(input logic pcw, irw, adr, mw, rw,
                                 input logic [1:0] res, a, b,
                                 input logic [2:0] alu,
                                 input logic done, ill);
        outs_t o;
        o.pcw = pcw; o.irw = irw; o.adr = adr; o.mw = mw; o.rw = rw;
        o.res = res; o.a = a; o.b = b; o.alu = alu;
        o.imm = imm_of(cur_op); o.done = done; o.ill = ill;
        return o;
    endfunction

    function automatic outs_t observe();
        outs_t o;
        o.pcw = bus.pc_write; o.irw = bus.ir_write; o.adr = bus.adr_source;
        o.mw = bus.mem_write; o.rw = bus.reg_write; o.res = bus.result_source;
        o.a = bus.alu_source_a; o.b = bus.alu_source_b; o.alu = bus.alu_control;
        o.imm = bus.imm_type; o.done = bus.instr_done; o.ill = bus.illegal;
        return o;
    endfunction

    task automatic push(input logic mr, input logic z, input outs_t e);
        step_t s;
        s.mr = mr; s.z = z; s.e = e;
        plan.push_back(s);
    endtask

    // Expected cycle table for one instruction; zmode 0/1 forces zero, 2 = random
    task automatic plan_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input int unsigned fs, input int unsigned ms, input int unsigned zmode);
        int unsigned fstall = fs;
        int unsigned mstall = ms;
        logic z;
        cur_op = op; cur_f3 = f3; cur_f7 = f7;
        plan.delete();
`ifndef MEM_WAIT_EN
        fstall = 0;
        mstall = 0;
`endif
        repeat (fstall) push(1'b0, rb(), mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0));
        push(need(), rb(), mk(1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0));
        push(rb(), rb(), mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0, 0));
        if (!is_legal(op, f3)) begin
            repeat (3) push(rb(), rb(), mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 1));
            return;
        end
        if (op == LW || op == SW)
            push(rb(), rb(), mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0));
        if (op == LW) begin
            repeat (mstall) push(1'b0, rb(), mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
            push(need(), rb(), mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
            push(rb(), rb(), mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 1, 0));
        end else if (op == SW) begin
            repeat (mstall) push(1'b0, rb(), mk(0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
            push(need(), rb(), mk(0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));
        end else if (op == BEQ) begin
            z = (zmode == 2) ? rb() : 1'(zmode);
            push(rb(), z, mk(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 1, 0));
        end else begin
            if (op == RT)
                push(rb(), rb(), mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu_of(f3, f7[5]), 0, 0));
            else if (op == IA)
                push(rb(), rb(), mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu_of(f3, 1'b0), 0, 0));
            else
                push(rb(), rb(), mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0, 0));
            push(rb(), rb(), mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));
        end
    endtask

    task automatic check(input string tag, input int unsigned idx, input outs_t e);
        outs_t o;
        o = observe();
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s step %0d: observed %b required %b", tag, idx, o, e);
        end
    endtask

    // Replay the first 'limit' cycles of the plan; starts just after a rising edge
    task automatic run_plan(input string tag, input int unsigned limit);
        for (int unsigned i = 0; i < plan.size() && i < limit; i++) begin
            bus.op_code   = cur_op;
            bus.func3     = cur_f3;
            bus.func7     = cur_f7;
            bus.mem_ready = plan[i].mr;
            bus.zero      = plan[i].z;
            @(negedge clk);
            check(tag, i, plan[i].e);
            @(posedge clk);
            #1;
        end
    endtask

    // Hold reset for n cycles; every strobe must stay low
    task automatic reset_cycles(input int unsigned n);
        logic [5:0] strobes;
        reset = 1'b1;
        for (int unsigned i = 0; i < n; i++) begin
            bus.mem_ready = rb();
            bus.zero      = rb();
            @(negedge clk);
            strobes = {bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write,
                       bus.instr_done, bus.illegal};
            vectors++;
            assert (strobes === 6'b000000) else begin
                miscompares++;
                $error("FAIL reset_strobes cycle %0d: observed %b required 000000", i, strobes);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    initial begin
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        int unsigned kind;
        logic [2:0]  alu_f3s [4];

        alu_f3s[0] = 3'b000; alu_f3s[1] = 3'b010; alu_f3s[2] = 3'b110; alu_f3s[3] = 3'b111;
        bus.op_code = LW; bus.func3 = 3'b010; bus.func7 = 7'd0;
        bus.zero = 1'b0; bus.mem_ready = 1'b1;
        cur_op = LW; cur_f3 = 3'b010; cur_f7 = 7'd0;

        reset_cycles(2);

        plan_instr(LW, 3'b010, 7'd0, 0, 0, 2);              run_plan("lw", 99);
        plan_instr(SW, 3'b010, 7'd0, 0, 2, 2);              run_plan("sw_stall", 99);
        plan_instr(RT, 3'b000, 7'b0100000, 0, 0, 2);        run_plan("r_sub", 99);
        plan_instr(RT, 3'b000, 7'b0000000, 1, 0, 2);        run_plan("r_add", 99);
        plan_instr(RT, 3'b111, 7'd0, 0, 0, 2);              run_plan("r_and", 99);
        plan_instr(RT, 3'b110, 7'd0, 0, 0, 2);              run_plan("r_or", 99);
        plan_instr(RT, 3'b010, 7'd0, 0, 0, 2);              run_plan("r_slt", 99);
        plan_instr(IA, 3'b000, 7'b0100000, 0, 0, 2);        run_plan("i_add_f7", 99);
        plan_instr(JAL, 3'b000, 7'd0, 0, 0, 2);             run_plan("jal", 99);
        plan_instr(BEQ, 3'b000, 7'd0, 0, 0, 1);             run_plan("beq_taken", 99);
        plan_instr(BEQ, 3'b000, 7'd0, 0, 0, 0);             run_plan("beq_not_taken", 99);
        plan_instr(LW, 3'b010, 7'd0, 2, 3, 2);              run_plan("lw_stall", 99);
        plan_instr(7'b1111111, 3'b000, 7'd0, 0, 0, 2);      run_plan("trap_op", 99);
        reset_cycles(1);
        plan_instr(BEQ, 3'b001, 7'd0, 0, 0, 2);             run_plan("trap_beq_f3", 99);
        reset_cycles(1);
        // Reset landing on the MEMWB cycle must suppress its write
        plan_instr(LW, 3'b010, 7'd0, 0, 0, 2);              run_plan("lw_abort", 4);
        reset_cycles(1);
        plan_instr(SW, 3'b010, 7'd0, 0, 2, 2);              run_plan("sw_abort", 4);
        reset_cycles(1);

        for (int unsigned n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 7);
            f7   = 7'($urandom);
            f3   = 3'($urandom);
            case (kind)
                0: op = LW;
                1: op = SW;
                2: begin op = RT; f3 = alu_f3s[$urandom_range(0, 3)]; end
                3: begin op = IA; f3 = alu_f3s[$urandom_range(0, 3)]; end
                4: op = JAL;
                5: begin op = BEQ; f3 = 3'b000; end
                6: op = 7'($urandom);
                default: op = (rb() != 1'b0) ? BEQ : RT;
            endcase
            plan_instr(op, f3, f7, $urandom_range(0, 3), $urandom_range(0, 3), 2);
            if ($urandom_range(0, 9) == 0) begin
                run_plan("rnd_abort", $urandom_range(1, 4));
                reset_cycles(1);
            end else begin
                run_plan("rnd", 99);
                if (!is_legal(op, f3)) reset_cycles(1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
